// File: rtl/dist_sort_pkg.sv
// Shared types and helpers for the streaming distance sorter:
// mode codes, FSM state encoding and the frame-size function.
package dist_sort_pkg;

  localparam int unsigned MODE_QPSK  = 0;
  localparam int unsigned MODE_8     = 1;
  localparam int unsigned MODE_QAM16 = 2;
  localparam int unsigned MODE_32    = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    DONE
  } state_e;

  // Frame size is 4 << mode, clipped to the largest frame the bank can hold.
  function automatic int unsigned active_size(input int unsigned modeCode,
                                              input int unsigned nMax);
    int unsigned size;
    case (modeCode)
      MODE_QPSK:  size = 4;
      MODE_8:     size = 8;
      MODE_QAM16: size = 16;
      MODE_32:    size = 32;
      default:    size = (modeCode > 27) ? nMax : (32'd4 << modeCode);
    endcase
    return (size > nMax) ? nMax : size;
  endfunction

endpackage

// File: rtl/dist_sort_stream_cmp_swap.sv
// Combinational compare-exchange of two unsigned words; with DIST_SORT_INDEX_EN
// defined, the arrival tags follow their values through the exchange.
module cmp_swap #(
  parameter int WIDTH = 8
`ifdef DIST_SORT_INDEX_EN
  , parameter int TAG_W = 4
`endif
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             swap_o
`ifdef DIST_SORT_INDEX_EN
  , input  logic [TAG_W-1:0] aTag_i
  , input  logic [TAG_W-1:0] bTag_i
  , output logic [TAG_W-1:0] loTag_o
  , output logic [TAG_W-1:0] hiTag_o
`endif
);

  // Strict compare keeps equal values in arrival order.
  assign swap_o = a_i > b_i;
  assign lo_o   = swap_o ? b_i : a_i;
  assign hi_o   = swap_o ? a_i : b_i;

`ifdef DIST_SORT_INDEX_EN
  assign loTag_o = swap_o ? bTag_i : aTag_i;
  assign hiTag_o = swap_o ? aTag_i : bTag_i;
`endif

endmodule

// File: rtl/dist_sort_stream.sv
// Streaming frame sorter: loads 4/8/16 distances two per beat, sorts with an
// odd-even transposition engine, then offers the frame. Option: DIST_SORT_INDEX_EN.
module dist_sort_stream
  import dist_sort_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_MAX  = 16,
  parameter int MODE_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*WIDTH-1:0]         in_data,
  input  logic [MODE_W-1:0]          mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_MAX*WIDTH-1:0]     out_data,
  output logic [$clog2(N_MAX):0]     out_count
`ifdef DIST_SORT_INDEX_EN
  , output logic [N_MAX*$clog2(N_MAX)-1:0] out_idx
`endif
);

  localparam int IDX_W = $clog2(N_MAX);
  localparam int CNT_W = IDX_W + 1;
  localparam int HALF  = N_MAX / 2;

  state_e               state_q;
  logic                 inReady_q;
  logic                 outValid_q;
  logic [N_MAX*WIDTH-1:0] outData_q;
  logic [CNT_W-1:0]     outCount_q;
  logic [CNT_W-1:0]     activeN_q;
  logic [CNT_W-1:0]     wrCnt_q;
  logic [CNT_W-1:0]     passCnt_q;
  logic [WIDTH-1:0]     bank_q [N_MAX];

  logic                 inFire;
  logic [IDX_W-1:0]     wrIdx;
  logic [IDX_W-1:0]     wrIdxHi;
  logic [WIDTH-1:0]     sortVal_d [N_MAX];
  logic [N_MAX*WIDTH-1:0] outData_d;

  logic [WIDTH-1:0]     evenLo [HALF];
  logic [WIDTH-1:0]     evenHi [HALF];
  logic [HALF-1:0]      evenSwp;
  logic [HALF-1:0]      evenEn;
  logic [WIDTH-1:0]     oddLo  [HALF-1];
  logic [WIDTH-1:0]     oddHi  [HALF-1];
  logic [HALF-2:0]      oddSwp;
  logic [HALF-2:0]      oddEn;

`ifdef DIST_SORT_INDEX_EN
  logic [IDX_W-1:0]     tag_q [N_MAX];
  logic [N_MAX*IDX_W-1:0] outIdx_q;
  logic [IDX_W-1:0]     sortTag_d [N_MAX];
  logic [N_MAX*IDX_W-1:0] outIdx_d;
  logic [IDX_W-1:0]     evenLoTag [HALF];
  logic [IDX_W-1:0]     evenHiTag [HALF];
  logic [IDX_W-1:0]     oddLoTag  [HALF-1];
  logic [IDX_W-1:0]     oddHiTag  [HALF-1];
`endif

  assign inFire  = in_valid && inReady_q;
  assign wrIdx   = wrCnt_q[IDX_W-1:0];
  assign wrIdxHi = {wrCnt_q[IDX_W-1:1], 1'b1};

  // Pairs straddling the active frame boundary are left untouched.
  for (genvar k = 0; k < HALF; k++) begin : gEven
    assign evenEn[k] = activeN_q > CNT_W'(2*k+1);
    cmp_swap #(
      .WIDTH(WIDTH)
`ifdef DIST_SORT_INDEX_EN
      , .TAG_W(IDX_W)
`endif
    ) uCmp (
      .a_i(bank_q[2*k]), .b_i(bank_q[2*k+1]),
      .lo_o(evenLo[k]), .hi_o(evenHi[k]), .swap_o(evenSwp[k])
`ifdef DIST_SORT_INDEX_EN
      , .aTag_i(tag_q[2*k]), .bTag_i(tag_q[2*k+1])
      , .loTag_o(evenLoTag[k]), .hiTag_o(evenHiTag[k])
`endif
    );
  end

  for (genvar k = 0; k < HALF-1; k++) begin : gOdd
    assign oddEn[k] = activeN_q > CNT_W'(2*k+2);
    cmp_swap #(
      .WIDTH(WIDTH)
`ifdef DIST_SORT_INDEX_EN
      , .TAG_W(IDX_W)
`endif
    ) uCmp (
      .a_i(bank_q[2*k+1]), .b_i(bank_q[2*k+2]),
      .lo_o(oddLo[k]), .hi_o(oddHi[k]), .swap_o(oddSwp[k])
`ifdef DIST_SORT_INDEX_EN
      , .aTag_i(tag_q[2*k+1]), .bTag_i(tag_q[2*k+2])
      , .loTag_o(oddLoTag[k]), .hiTag_o(oddHiTag[k])
`endif
    );
  end

  always_comb begin
    for (int i = 0; i < N_MAX; i++) begin
      sortVal_d[i] = bank_q[i];
`ifdef DIST_SORT_INDEX_EN
      sortTag_d[i] = tag_q[i];
`endif
    end
    if (!passCnt_q[0]) begin
      for (int k = 0; k < HALF; k++) begin
        if (evenEn[k] && evenSwp[k]) begin
          sortVal_d[2*k]   = evenLo[k];
          sortVal_d[2*k+1] = evenHi[k];
`ifdef DIST_SORT_INDEX_EN
          sortTag_d[2*k]   = evenLoTag[k];
          sortTag_d[2*k+1] = evenHiTag[k];
`endif
        end
      end
    end else begin
      for (int k = 0; k < HALF-1; k++) begin
        if (oddEn[k] && oddSwp[k]) begin
          sortVal_d[2*k+1] = oddLo[k];
          sortVal_d[2*k+2] = oddHi[k];
`ifdef DIST_SORT_INDEX_EN
          sortTag_d[2*k+1] = oddLoTag[k];
          sortTag_d[2*k+2] = oddHiTag[k];
`endif
        end
      end
    end
  end

  always_comb begin
    outData_d = '0;
`ifdef DIST_SORT_INDEX_EN
    outIdx_d  = '0;
`endif
    for (int i = 0; i < N_MAX; i++) begin
      if (CNT_W'(i) < activeN_q) begin
        outData_d[i*WIDTH +: WIDTH] = bank_q[i];
`ifdef DIST_SORT_INDEX_EN
        outIdx_d[i*IDX_W +: IDX_W]  = tag_q[i];
`endif
      end
    end
  end

  // DONE spends one cycle capturing the masked bank before raising out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCount_q <= '0;
      activeN_q  <= '0;
      wrCnt_q    <= '0;
      passCnt_q  <= '0;
      for (int i = 0; i < N_MAX; i++) begin
        bank_q[i] <= '0;
`ifdef DIST_SORT_INDEX_EN
        tag_q[i]  <= '0;
`endif
      end
`ifdef DIST_SORT_INDEX_EN
      outIdx_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          inReady_q <= 1'b1;
          if (inFire) begin
            activeN_q <= CNT_W'(active_size(32'(mode), 32'(N_MAX)));
            bank_q[0] <= in_data[WIDTH-1:0];
            bank_q[1] <= in_data[2*WIDTH-1:WIDTH];
`ifdef DIST_SORT_INDEX_EN
            tag_q[0]  <= IDX_W'(0);
            tag_q[1]  <= IDX_W'(1);
`endif
            wrCnt_q   <= CNT_W'(2);
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (inFire) begin
            bank_q[wrIdx]   <= in_data[WIDTH-1:0];
            bank_q[wrIdxHi] <= in_data[2*WIDTH-1:WIDTH];
`ifdef DIST_SORT_INDEX_EN
            tag_q[wrIdx]    <= wrIdx;
            tag_q[wrIdxHi]  <= wrIdxHi;
`endif
            wrCnt_q <= wrCnt_q + CNT_W'(2);
            if (wrCnt_q + CNT_W'(2) == activeN_q) begin
              inReady_q <= 1'b0;
              passCnt_q <= '0;
              state_q   <= SORT;
            end
          end
        end
        SORT: begin
          for (int i = 0; i < N_MAX; i++) begin
            bank_q[i] <= sortVal_d[i];
`ifdef DIST_SORT_INDEX_EN
            tag_q[i]  <= sortTag_d[i];
`endif
          end
          if (passCnt_q == activeN_q - CNT_W'(1)) begin
            state_q <= DONE;
          end else begin
            passCnt_q <= passCnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (!outValid_q) begin
            outValid_q <= 1'b1;
            outData_q  <= outData_d;
            outCount_q <= activeN_q;
`ifdef DIST_SORT_INDEX_EN
            outIdx_q   <= outIdx_d;
`endif
          end else if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_count = outCount_q;
`ifdef DIST_SORT_INDEX_EN
  assign out_idx   = outIdx_q;
`endif

endmodule
